// File: rtl/playbus_seq_ctrl.sv
// rtl/playbus_seq_ctrl.sv - PlayBus bus-operation controller: FUNC decode, source enable and sink strobe sequencing
//
// Purpose:
//   Front-panel bus controller between the GO/FUNC/ADD controls and the ROM, RAM,
//   switch buffer and LED latch. Static functions (FUNC 0/1) drive a source
//   combinationally while idle. Dynamic functions (FUNC 2..6) run one transfer:
//   SETUP -> WRITE (WR_CYCLES) -> HOLD (HOLD_CYCLES) -> REL.
//
// Optional feature macro: PLAYBUS_BLOCK_COPY_EN
//   Defined   : FUNC 7 copies ROM->RAM over every address 0..2**AW-1.
//   Undefined : FUNC 7 is an inert static function and GO is ignored for it.
//
// Ports:
//   CK2HZ    in   1   system clock, rising edge
//   n_CLR    in   1   asynchronous active-low reset
//   GO       in   1   start request for dynamic functions, level-sensitive
//   FUNC     in   3   function select
//   ADD      in   AW  front-panel address
//   A_OUT    out  AW  address to ROM/RAM (addr_q while busy, else ADD)
//   n_ROMO   out  1   ROM output enable, active-low
//   n_RAMO   out  1   RAM output enable, active-low
//   n_SWBEN  out  1   switch buffer enable, active-low
//   n_RAMW   out  1   RAM write strobe, active-low
//   LEDLTCH  out  1   LED latch strobe, active-high, registered
//   BUSY     out  1   high in any state other than IDLE
//   DONE     out  1   one-clock pulse on entry to REL
//   St       out  3   current state encoding
module playbus_seq_ctrl #(
    parameter int AW          = 4,
    parameter int WR_CYCLES   = 1,
    parameter int HOLD_CYCLES = 1
) (
    input  logic          CK2HZ,
    input  logic          n_CLR,
    input  logic          GO,
    input  logic [2:0]    FUNC,
    input  logic [AW-1:0] ADD,
    output logic [AW-1:0] A_OUT,
    output logic          n_ROMO,
    output logic          n_RAMO,
    output logic          n_SWBEN,
    output logic          n_RAMW,
    output logic          LEDLTCH,
    output logic          BUSY,
    output logic          DONE,
    output logic [2:0]    St
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_REL   = 3'd4;

    // Counters compare against the last count rather than the length so a
    // phase of one clock needs no special case.
    localparam logic [2:0] WR_LAST   = 3'(WR_CYCLES - 1);
    localparam logic [2:0] HOLD_LAST = 3'(HOLD_CYCLES - 1);
`ifdef PLAYBUS_BLOCK_COPY_EN
    localparam logic [AW-1:0] ADDR_LAST = '1;
`endif

    logic [2:0]    st_q, st_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [2:0]    fq_q, fq_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          ramw_q, ramw_d;
    logic          led_q, led_d;
    logic          done_q, done_d;
    logic          next_strobe;
    logic          rom_en, ram_en, sw_en;

    function automatic logic is_start(input logic [2:0] f);
`ifdef PLAYBUS_BLOCK_COPY_EN
        return (f >= 3'd2);
`else
        return (f >= 3'd2) && (f <= 3'd6);
`endif
    endfunction

    function automatic logic src_rom(input logic [2:0] f);
        return (f == 3'd2) || (f == 3'd6) || (f == 3'd7);
    endfunction

    function automatic logic src_sw(input logic [2:0] f);
        return (f == 3'd3) || (f == 3'd5);
    endfunction

    function automatic logic sink_ram(input logic [2:0] f);
        return (f == 3'd2) || (f == 3'd3) || (f == 3'd7);
    endfunction

    function automatic logic sink_led(input logic [2:0] f);
        return (f >= 3'd4) && (f <= 3'd6);
    endfunction

    always_ff @(posedge CK2HZ or negedge n_CLR) begin
        if (!n_CLR) begin
            st_q   <= S_IDLE;
            cnt_q  <= '0;
            fq_q   <= '0;
            addr_q <= '0;
            ramw_q <= 1'b0;
            led_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            fq_q   <= fq_d;
            addr_q <= addr_d;
            ramw_q <= ramw_d;
            led_q  <= led_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        fq_d   = fq_q;
        addr_d = addr_q;
        case (st_q)
            S_IDLE: begin
                if (GO && is_start(FUNC)) begin
                    st_d  = S_SETUP;
                    fq_d  = FUNC;
                    cnt_d = '0;
`ifdef PLAYBUS_BLOCK_COPY_EN
                    addr_d = (FUNC == 3'd7) ? '0 : ADD;
`else
                    addr_d = ADD;
`endif
                end
            end
            S_SETUP: begin
                st_d  = S_WRITE;
                cnt_d = '0;
            end
            S_WRITE: begin
                if (cnt_q == WR_LAST) begin
                    st_d  = S_HOLD;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    st_d  = S_REL;
`ifdef PLAYBUS_BLOCK_COPY_EN
                    // Block copy stops after the last address, so addr_q never wraps.
                    if (fq_q == 3'd7 && addr_q != ADDR_LAST) begin
                        st_d   = S_SETUP;
                        addr_d = addr_q + AW'(1);
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_REL: begin
                if (!GO) begin
                    st_d = S_IDLE;
                end
            end
            default: begin
                st_d  = S_IDLE;
                cnt_d = '0;
            end
        endcase
    end

    // Strobes are registered from the next state, so they are high for exactly
    // the clocks spent in WRITE and can never overlap (one sink per function).
    always_comb begin
        next_strobe = (st_d == S_WRITE);
        ramw_d      = next_strobe && sink_ram(fq_d);
        led_d       = next_strobe && sink_led(fq_d);
        done_d      = (st_d == S_REL) && (st_q != S_REL);
    end

    always_comb begin
        rom_en = 1'b0;
        ram_en = 1'b0;
        sw_en  = 1'b0;
        // Gating with n_CLR keeps every enable off during reset even while a
        // static FUNC is selected.
        if (n_CLR) begin
            case (st_q)
                S_IDLE: begin
                    rom_en = (FUNC == 3'd0);
                    ram_en = (FUNC == 3'd1);
                end
                S_SETUP, S_WRITE, S_HOLD: begin
                    rom_en = src_rom(fq_q);
                    sw_en  = src_sw(fq_q);
                    ram_en = (fq_q == 3'd4);
                end
                default: begin
                    rom_en = 1'b0;
                end
            endcase
        end
        n_ROMO  = ~rom_en;
        n_RAMO  = ~ram_en;
        n_SWBEN = ~sw_en;
        n_RAMW  = ~ramw_q;
        LEDLTCH = led_q;
        BUSY    = (st_q != S_IDLE);
        DONE    = done_q;
        St      = st_q;
        A_OUT   = (st_q != S_IDLE) ? addr_q : ADD;
    end

endmodule

// File: tb/tb_playbus_seq_ctrl.sv
// tb/tb_playbus_seq_ctrl.sv - self-checking bench for playbus_seq_ctrl
module tb_playbus_seq_ctrl;
    localparam int AW = 4;
    localparam int WA = 1;
    localparam int HA = 1;
    localparam int WB = 3;
    localparam int HB = 2;
`ifdef PLAYBUS_BLOCK_COPY_EN
    localparam bit BLK = 1'b1;
`else
    localparam bit BLK = 1'b0;
`endif

    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic          n_clr = 1'b1;
    logic          go = 1'b0;
    logic [2:0]    func = 3'd0;
    logic [AW-1:0] add = '0;

    logic [AW-1:0] a_out_a, a_out_b;
    logic          n_romo_a, n_ramo_a, n_swben_a, n_ramw_a, ledltch_a, busy_a, done_a;
    logic          n_romo_b, n_ramo_b, n_swben_b, n_ramw_b, ledltch_b, busy_b, done_b;
    logic [2:0]    st_a, st_b;

    int n_cmp = 0;
    int n_bad = 0;

    playbus_seq_ctrl #(.AW(AW), .WR_CYCLES(WA), .HOLD_CYCLES(HA)) dut_a (
        .CK2HZ(ck), .n_CLR(n_clr), .GO(go), .FUNC(func), .ADD(add),
        .A_OUT(a_out_a), .n_ROMO(n_romo_a), .n_RAMO(n_ramo_a), .n_SWBEN(n_swben_a),
        .n_RAMW(n_ramw_a), .LEDLTCH(ledltch_a), .BUSY(busy_a), .DONE(done_a), .St(st_a)
    );

    playbus_seq_ctrl #(.AW(AW), .WR_CYCLES(WB), .HOLD_CYCLES(HB)) dut_b (
        .CK2HZ(ck), .n_CLR(n_clr), .GO(go), .FUNC(func), .ADD(add),
        .A_OUT(a_out_b), .n_ROMO(n_romo_b), .n_RAMO(n_ramo_b), .n_SWBEN(n_swben_b),
        .n_RAMW(n_ramw_b), .LEDLTCH(ledltch_b), .BUSY(busy_b), .DONE(done_b), .St(st_b)
    );

    wire [13:0] obs_a = {st_a, busy_a, done_a, a_out_a, n_romo_a, n_ramo_a, n_swben_a, n_ramw_a, ledltch_a};
    wire [13:0] obs_b = {st_b, busy_b, done_b, a_out_b, n_romo_b, n_ramo_b, n_swben_b, n_ramw_b, ledltch_b};

    function automatic bit is_dyn(input int f);
        return (f >= 2 && f <= 6) || (f == 7 && BLK);
    endfunction

    function automatic int n_xfers(input int f);
        return (f == 7) ? (1 << AW) : 1;
    endfunction

    // Clock edge at which the controller is back in IDLE: REL is entered after
    // all transfers, and left on the first edge that sees GO low.
    function automatic int idle_edge(input int w, input int h, input int f, input int g);
        int t;
        t = n_xfers(f) * (1 + w + h) + 1;
        return ((t > g) ? t : g) + 1;
    endfunction

    // Expected output vector after rising edge n of a run started with FUNC=f,
    // ADD=a and GO held high for edges 1..g; cf/ca are the live FUNC/ADD inputs.
    function automatic logic [13:0] model(input int w, input int h, input int f, input int a,
                                          input int g, input int n,
                                          input logic [2:0] cf, input logic [3:0] ca);
        int nx, l, t, ie, idx, off, base;
        logic [2:0] st;
        logic done;
        logic [3:0] adr;
        bit rom, ram, sw, rw, led;
        nx = n_xfers(f);
        l = 1 + w + h;
        t = nx * l + 1;
        ie = idle_edge(w, h, f, g);
        base = (f == 7) ? 0 : a;
        st = 3'd0; done = 1'b0; adr = ca;
        rom = 0; ram = 0; sw = 0; rw = 0; led = 0;
        if (is_dyn(f) && g >= 1 && n >= 1) begin
            if (n < t) begin
                idx = (n - 1) / l;
                off = (n - 1) % l;
                st = (off == 0) ? 3'd1 : ((off <= w) ? 3'd2 : 3'd3);
                adr = 4'(base + idx);
            end else if (n < ie) begin
                st = 3'd4;
                done = (n == t);
                adr = 4'(base + nx - 1);
            end
        end
        if (st >= 3'd1 && st <= 3'd3) begin
            rom = (f == 2 || f == 6 || f == 7);
            sw  = (f == 3 || f == 5);
            ram = (f == 4);
            rw  = (st == 3'd2) && (f == 2 || f == 3 || f == 7);
            led = (st == 3'd2) && (f >= 4 && f <= 6);
        end else if (st == 3'd0) begin
            rom = (cf == 3'd0);
            ram = (cf == 3'd1);
        end
        return {st, (st != 3'd0), done, adr, !rom, !ram, !sw, !rw, led};
    endfunction

    // wiggle: 0 inputs steady, 1 random FUNC/ADD after start, 2 FUNC forced to 4 after start
    task automatic run_sequence(input string name, input int f, input int a, input int g, input int wiggle);
        int ncyc, ia, ib;
        logic [13:0] ea, eb;
        if (is_dyn(f) && g >= 1) begin
            ia = idle_edge(WA, HA, f, g);
            ib = idle_edge(WB, HB, f, g);
            ncyc = ((ia > ib) ? ia : ib) + 2;
        end else begin
            ncyc = g + 3;
        end
        @(negedge ck);
        func = 3'(f);
        add = 4'(a);
        go = (g >= 1);
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge ck);
            #1;
            ea = model(WA, HA, f, a, g, n, func, add);
            eb = model(WB, HB, f, a, g, n, func, add);
            n_cmp++;
            if (obs_a !== ea) begin
                n_bad++;
                $display("FAIL %s dut_a edge %0d: got %b want %b", name, n, obs_a, ea);
            end
            n_cmp++;
            if (obs_b !== eb) begin
                n_bad++;
                $display("FAIL %s dut_b edge %0d: got %b want %b", name, n, obs_b, eb);
            end
            @(negedge ck);
            go = (n + 1 <= g);
            if (is_dyn(f) && g >= 1) begin
                if (wiggle == 1) begin
                    func = 3'($urandom);
                    add = 4'($urandom);
                end else if (wiggle == 2) begin
                    func = 3'd4;
                end
            end
        end
        go = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] exp_v;
        func = 3'd0;
        add = 4'd3;
        go = 1'b0;
        #1 n_clr = 1'b0;
        repeat (2) @(posedge ck);
        #1;
        exp_v = {3'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        n_cmp++;
        if (obs_a !== exp_v) begin
            n_bad++;
            $display("FAIL reset dut_a: got %b want %b", obs_a, exp_v);
        end
        n_cmp++;
        if (obs_b !== exp_v) begin
            n_bad++;
            $display("FAIL reset dut_b: got %b want %b", obs_b, exp_v);
        end
        @(negedge ck);
        n_clr = 1'b1;
    endtask

    task automatic test_reset_mid_write();
        @(negedge ck);
        func = 3'd3;
        add = 4'd5;
        go = 1'b1;
        repeat (2) @(posedge ck);
        #1;
        n_cmp++;
        if ({st_a, n_ramw_a, n_swben_a, st_b, n_ramw_b, n_swben_b} !== {3'd2, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_write_pre: got a st=%0d ramw=%b sw=%b b st=%0d ramw=%b sw=%b want st=2 ramw=0 sw=0",
                     st_a, n_ramw_a, n_swben_a, st_b, n_ramw_b, n_swben_b);
        end
        #2 n_clr = 1'b0;
        #1;
        n_cmp++;
        if ({st_a, n_ramw_a, n_swben_a} !== {3'd0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL mid_write_clr dut_a: got st=%0d ramw=%b sw=%b want st=0 ramw=1 sw=1", st_a, n_ramw_a, n_swben_a);
        end
        n_cmp++;
        if ({st_b, n_ramw_b, n_swben_b} !== {3'd0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL mid_write_clr dut_b: got st=%0d ramw=%b sw=%b want st=0 ramw=1 sw=1", st_b, n_ramw_b, n_swben_b);
        end
        go = 1'b0;
        @(negedge ck);
        n_clr = 1'b1;
    endtask

    task automatic test_static();
        run_sequence("static_rom", 0, 6, 0, 0);
        run_sequence("static_ram", 1, 11, 0, 0);
        run_sequence("static_rom_go", 0, 2, 3, 0);
        run_sequence("static_ram_go", 1, 7, 3, 0);
    endtask

    task automatic test_led_sequence();
        run_sequence("sw_to_led", 5, 4, 3, 0);
    endtask

    task automatic test_func_switch();
        run_sequence("rom_to_ram_switch", 2, 9, 1, 2);
    endtask

    task automatic test_func7();
        run_sequence("func7", 7, 13, 1, 0);
    endtask

    task automatic test_go_held();
        run_sequence("go_held", 3, 10, 14, 0);
    endtask

    task automatic test_back_to_back();
        run_sequence("b2b_first", 4, 1, 1, 0);
        run_sequence("b2b_second", 6, 15, 2, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_sequence("random", int'($urandom_range(7)), int'($urandom_range(15)),
                         int'($urandom_range(1, 20)), 1);
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_led_sequence();
        test_func_switch();
        test_reset_mid_write();
        test_func7();
        test_go_held();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
